// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one enable/ack memory slave port.
// The grant holds until ack, abort or timeout, and every grant is followed by one Idle cycle.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_NUM   = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  m0_rd_en,
    input  logic                  m0_wr_en,
    input  logic [BYTE_NUM-1:0]   m0_byte_en,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_rd_en,
    input  logic                  m1_wr_en,
    input  logic [BYTE_NUM-1:0]   m1_byte_en,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_rd_en,
    output logic                  s_wr_en,
    output logic [BYTE_NUM-1:0]   s_byte_en,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wr_data,
    input  logic [DATA_WIDTH-1:0] s_rd_data,
    input  logic                  s_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    localparam bit                   TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 last_grant_r;
    logic                 last_grant_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    logic req0_s;
    logic req1_s;
    logic busy_s;
    logic sel_s;
    logic sel_rd_s;
    logic sel_wr_s;
    logic sel_req_s;
    logic timeout_s;

    // Request decode and selection of the currently granted master.
    always_comb begin
        req0_s    = m0_rd_en | m0_wr_en;
        req1_s    = m1_rd_en | m1_wr_en;
        busy_s    = (state_r != ST_IDLE);
        sel_s     = (state_r == ST_BUSY1);
        sel_rd_s  = sel_s ? m1_rd_en : m0_rd_en;
        sel_wr_s  = sel_s ? m1_wr_en : m0_wr_en;
        sel_req_s = sel_rd_s | sel_wr_s;
        // A withdrawn request is an abort, which outranks a coincident timeout.
        timeout_s = TIMEOUT_EN && busy_s && sel_req_s && !s_ack && (cnt_r == TIMEOUT_CNT);
    end

    // State, round-robin pointer and timeout counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            cnt_r        <= CNT_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    // Next-state logic: arbitration in Idle, completion/abort/timeout in Busy.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        cnt_nxt_s        = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (req0_s && req1_s) begin
                    if (last_grant_r) begin
                        state_nxt_s      = ST_BUSY0;
                        last_grant_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s      = ST_BUSY1;
                        last_grant_nxt_s = 1'b1;
                    end
                end else if (req0_s) begin
                    state_nxt_s      = ST_BUSY0;
                    last_grant_nxt_s = 1'b0;
                end else if (req1_s) begin
                    state_nxt_s      = ST_BUSY1;
                    last_grant_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (!s_ack && (cnt_r != CNT_MAX)) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (s_ack || !sel_req_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Slave-side drive and per-master ack/err, all combinational from the grant.
    always_comb begin
        s_rd_en   = 1'b0;
        s_wr_en   = 1'b0;
        s_byte_en = {BYTE_NUM{1'b0}};
        s_addr    = {ADDR_WIDTH{1'b0}};
        s_wr_data = {DATA_WIDTH{1'b0}};
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        if (busy_s) begin
            s_rd_en   = sel_rd_s & ~timeout_s;
            s_wr_en   = sel_wr_s & ~sel_rd_s & ~timeout_s;
            s_byte_en = sel_s ? m1_byte_en : m0_byte_en;
            s_addr    = sel_s ? m1_addr    : m0_addr;
            s_wr_data = sel_s ? m1_wr_data : m0_wr_data;
            if (s_ack || timeout_s) begin
                if (sel_s) begin
                    m1_ack = 1'b1;
                    m1_err = timeout_s;
                end else begin
                    m0_ack = 1'b1;
                    m0_err = timeout_s;
                end
            end else begin
                m0_ack = 1'b0;
                m1_ack = 1'b0;
            end
        end else begin
            s_rd_en = 1'b0;
        end
    end

    assign m0_rd_data = s_rd_data;
    assign m1_rd_data = s_rd_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, reset corner cases,
// then randomized masters/slave checked against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int BN  = 8;
    localparam int TMO = 4;

    localparam logic [AW-1:0] A0  = 64'h0000_0000_0000_1000;
    localparam logic [AW-1:0] A1  = 64'h0000_0000_0000_2000;
    localparam logic [BN-1:0] BE0 = 8'hFF;
    localparam logic [BN-1:0] BE1 = 8'h0F;
    localparam logic [DW-1:0] D0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] D1  = 64'h0000_0000_DEAD_BEEF;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          m_rd [2];
    logic          m_wr [2];
    logic [BN-1:0] m_be [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_rd_en, s_wr_en;
    logic [BN-1:0] s_byte_en;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wr_data;
    logic [DW-1:0] s_rd_data;
    logic          s_ack;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_NUM(BN), .TIMEOUT(TMO), .CNT_WIDTH(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_rd_en(m_rd[0]), .m0_wr_en(m_wr[0]), .m0_byte_en(m_be[0]), .m0_addr(m_addr[0]),
        .m0_wr_data(m_wd[0]), .m0_rd_data(m0_rd_data), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_rd_en(m_rd[1]), .m1_wr_en(m_wr[1]), .m1_byte_en(m_be[1]), .m1_addr(m_addr[1]),
        .m1_wr_data(m_wd[1]), .m1_rd_data(m1_rd_data), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_byte_en(s_byte_en), .s_addr(s_addr),
        .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_ack(s_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rd0, wr0, rd1, wr1, sack;
        logic [1:0] own;   // 0/1 = master driving the slave, 2 = nobody
        logic       srd, swr, ack0, err0, ack1, err1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rd0, wr0, rd1, wr1, sack, input logic [1:0] own,
                                input logic srd, swr, ack0, err0, ack1, err1);
        vec_t v;
        v.rd0 = rd0; v.wr0 = wr0; v.rd1 = rd1; v.wr1 = wr1; v.sack = sack; v.own = own;
        v.srd = srd; v.swr = swr; v.ack0 = ack0; v.err0 = err0; v.ack1 = ack1; v.err1 = err1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle_inputs();
        for (int x = 0; x < 2; x++) begin
            m_rd[x] = 1'b0;
            m_wr[x] = 1'b0;
        end
        s_ack     = 1'b0;
        s_rd_data = 64'h0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [AW-1:0] ea;
        logic [BN-1:0] eb;
        logic [DW-1:0] ed;
        logic [DW-1:0] rdv;
        rdv = 64'hA5A5_0000_0000_0000 + 64'(idx);
        m_rd[0] = v.rd0; m_wr[0] = v.wr0; m_rd[1] = v.rd1; m_wr[1] = v.wr1;
        s_ack = v.sack; s_rd_data = rdv;
        ea = (v.own == 2'd0) ? A0  : (v.own == 2'd1) ? A1  : 64'h0;
        eb = (v.own == 2'd0) ? BE0 : (v.own == 2'd1) ? BE1 : 8'h00;
        ed = (v.own == 2'd0) ? D0  : (v.own == 2'd1) ? D1  : 64'h0;
        #2;
        chk($sformatf("v%0d s_rd_en", idx), 64'(s_rd_en), 64'(v.srd));
        chk($sformatf("v%0d s_wr_en", idx), 64'(s_wr_en), 64'(v.swr));
        chk($sformatf("v%0d s_addr", idx), s_addr, ea);
        chk($sformatf("v%0d s_byte_en", idx), 64'(s_byte_en), 64'(eb));
        chk($sformatf("v%0d s_wr_data", idx), s_wr_data, ed);
        chk($sformatf("v%0d m0_ack", idx), 64'(m0_ack), 64'(v.ack0));
        chk($sformatf("v%0d m0_err", idx), 64'(m0_err), 64'(v.err0));
        chk($sformatf("v%0d m1_ack", idx), 64'(m1_ack), 64'(v.ack1));
        chk($sformatf("v%0d m1_err", idx), 64'(m1_err), 64'(v.err1));
        chk($sformatf("v%0d m0_rd_data", idx), m0_rd_data, rdv);
        chk($sformatf("v%0d m1_rd_data", idx), m1_rd_data, rdv);
        @(posedge clock);
        #1;
    endtask

    // Transaction-level reference: who owns the bus and how long it has waited.
    int   owner;
    int   last;
    int   waited;
    logic active [2];

    initial begin
        // Reset state, with requests and a stray ack present
        reset_n = 1'b0;
        set_idle_inputs();
        m_be[0] = BE0; m_addr[0] = A0; m_wd[0] = D0;
        m_be[1] = BE1; m_addr[1] = A1; m_wd[1] = D1;
        m_rd[0] = 1'b1; m_wr[1] = 1'b1; s_ack = 1'b1;
        #3;
        chk("reset s_rd_en", 64'(s_rd_en), 64'h0);
        chk("reset s_wr_en", 64'(s_wr_en), 64'h0);
        chk("reset s_addr", s_addr, 64'h0);
        chk("reset m0_ack", 64'(m0_ack), 64'h0);
        chk("reset m1_ack", 64'(m1_ack), 64'h0);
        set_idle_inputs();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Round robin after reset: m0, m1, m0, m1 with one Idle between grants
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mk(1,0,0,1,1, 2'd2, 0,0,0,0,0,0));
            tbl.push_back(mk(1,0,0,1,1, 2'd0, 1,0,1,0,0,0));
            tbl.push_back(mk(1,0,0,1,1, 2'd2, 0,0,0,0,0,0));
            tbl.push_back(mk(1,0,0,1,1, 2'd1, 0,1,0,0,1,0));
        end
        tbl.push_back(mk(0,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        // Single m0 read, slave acks three cycles after s_rd_en rises
        tbl.push_back(mk(1,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 2'd0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1, 2'd0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        // m1 write times out on Busy cycle 5, then re-granted and acked exactly at the limit
        tbl.push_back(mk(0,0,0,1,0, 2'd2, 0,0,0,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,1,0, 2'd1, 0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 2'd1, 0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,1,0, 2'd2, 0,0,0,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,1,0, 2'd1, 0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1, 2'd1, 0,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        // Abort: m0 withdraws before ack, bus returns to Idle without an ack
        tbl.push_back(mk(1,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 2'd0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2'd2, 0,0,0,0,0,0));
        // Read and write both asserted: read wins
        tbl.push_back(mk(1,1,0,0,0, 2'd2, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1, 2'd0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 2'd2, 0,0,0,0,0,0));

        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Reset mid-Busy: enables drop at once, and m0 regains priority afterwards
        set_idle_inputs();
        m_rd[0] = 1'b1;
        @(posedge clock);
        #2;
        chk("pre-reset s_rd_en", 64'(s_rd_en), 64'h1);
        reset_n = 1'b0;
        #1;
        s_ack = 1'b1;
        #1;
        chk("mid-reset s_rd_en", 64'(s_rd_en), 64'h0);
        chk("mid-reset s_addr", s_addr, 64'h0);
        chk("mid-reset m0_ack", 64'(m0_ack), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        s_ack = 1'b0;
        m_rd[0] = 1'b1;
        m_wr[1] = 1'b1;
        @(posedge clock);
        #2;
        chk("post-reset grant addr", s_addr, A0);
        chk("post-reset s_rd_en", 64'(s_rd_en), 64'h1);
        chk("post-reset s_wr_en", 64'(s_wr_en), 64'h0);
        set_idle_inputs();
        @(posedge clock);
        #1;

        // Randomized phase against the reference model
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        owner = -1; last = 1; waited = 0;
        active[0] = 1'b0; active[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic          e_srd, e_swr, req, tmo;
            logic [AW-1:0] e_addr;
            logic [BN-1:0] e_be;
            logic [DW-1:0] e_wd;
            logic          e_ack [2];
            logic          e_err [2];
            for (int x = 0; x < 2; x++) begin
                if (!active[x]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int k;
                        k = $urandom_range(0, 2);
                        active[x] = 1'b1;
                        m_rd[x]   = (k != 1);
                        m_wr[x]   = (k != 0);
                        m_addr[x] = {$urandom, $urandom};
                        m_wd[x]   = {$urandom, $urandom};
                        m_be[x]   = 8'($urandom);
                    end else begin
                        m_rd[x] = 1'b0;
                        m_wr[x] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    active[x] = 1'b0;
                    m_rd[x]   = 1'b0;
                    m_wr[x]   = 1'b0;
                end
            end
            s_ack     = ($urandom_range(0, 3) == 0);
            s_rd_data = {$urandom, $urandom};

            e_srd = 1'b0; e_swr = 1'b0; e_addr = 64'h0; e_be = 8'h00; e_wd = 64'h0;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
            req = 1'b0; tmo = 1'b0;
            if (owner >= 0) begin
                req    = m_rd[owner] | m_wr[owner];
                tmo    = (TMO != 0) && (waited == TMO) && !s_ack && req;
                e_srd  = m_rd[owner] && !tmo;
                e_swr  = m_wr[owner] && !m_rd[owner] && !tmo;
                e_addr = m_addr[owner];
                e_be   = m_be[owner];
                e_wd   = m_wd[owner];
                if (s_ack || tmo) begin
                    e_ack[owner] = 1'b1;
                    e_err[owner] = tmo;
                end
            end
            #2;
            chk($sformatf("r%0d s_rd_en", cyc), 64'(s_rd_en), 64'(e_srd));
            chk($sformatf("r%0d s_wr_en", cyc), 64'(s_wr_en), 64'(e_swr));
            chk($sformatf("r%0d s_addr", cyc), s_addr, e_addr);
            chk($sformatf("r%0d s_byte_en", cyc), 64'(s_byte_en), 64'(e_be));
            chk($sformatf("r%0d s_wr_data", cyc), s_wr_data, e_wd);
            chk($sformatf("r%0d m0_ack", cyc), 64'(m0_ack), 64'(e_ack[0]));
            chk($sformatf("r%0d m0_err", cyc), 64'(m0_err), 64'(e_err[0]));
            chk($sformatf("r%0d m1_ack", cyc), 64'(m1_ack), 64'(e_ack[1]));
            chk($sformatf("r%0d m1_err", cyc), 64'(m1_err), 64'(e_err[1]));
            chk($sformatf("r%0d m0_rd_data", cyc), m0_rd_data, s_rd_data);
            chk($sformatf("r%0d m1_rd_data", cyc), m1_rd_data, s_rd_data);

            if (owner < 0) begin
                logic r0, r1;
                r0 = m_rd[0] | m_wr[0];
                r1 = m_rd[1] | m_wr[1];
                if (r0 || r1) begin
                    owner  = (r0 && r1) ? (1 - last) : (r0 ? 0 : 1);
                    last   = owner;
                    waited = 0;
                end
            end else if (s_ack || !req || tmo) begin
                owner = -1;
            end else begin
                waited = (waited < 255) ? waited + 1 : 255;
            end
            for (int x = 0; x < 2; x++) begin
                if (e_ack[x]) active[x] = 1'b0;
            end
            @(posedge clock);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares a single memory/bus slave port between two requesters using the enable/ack handshake already used by the core.
  - Master 0 is instruction fetch.
  - Master 1 is load/store.
- Round-robin arbitration with grant lock until ack, per-transaction timeout with bus-error reporting, and abort on request withdrawal.
- Sits between core/fetch logic and the memory or bus interconnect.

Parameters:
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width
- BYTE_NUM, 8, byte-enable width (DATA_WIDTH/8)
- TIMEOUT, 255, maximum Busy cycles without ack before error; 0 disables timeout
- CNT_WIDTH, 8, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active-low
- m0_rd_en  in  1  master 0 read request, held until m0_ack
- m0_wr_en  in  1  master 0 write request, held until m0_ack
- m0_byte_en  in  BYTE_NUM  master 0 byte enables
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wr_data  in  DATA_WIDTH  master 0 write data
- m0_rd_data  out  DATA_WIDTH  read data to master 0
- m0_ack  out  1  master 0 transaction done
- m0_err  out  1  master 0 timeout error, qualifies m0_ack
- m1_*  same set as m0_*, for master 1
- s_rd_en  out  1  slave read request
- s_wr_en  out  1  slave write request
- s_byte_en  out  BYTE_NUM  slave byte enables
- s_addr  out  ADDR_WIDTH  slave address
- s_wr_data  out  DATA_WIDTH  slave write data
- s_rd_data  in  DATA_WIDTH  slave read data
- s_ack  in  1  slave done; must not depend combinationally on s_rd_en or s_wr_en

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = Idle, last_grant = 1, counter = 0.
  - All s_* outputs, mX_ack and mX_err are 0.
  - Reset mid-transaction drops it silently; no ack is issued.
- Request definition: reqX = mX_rd_en | mX_wr_en.
- States and transitions:
  - Idle: s_* outputs held 0.
    - Only req0: next state Busy0.
    - Only req1: next state Busy1.
    - Both: grant the master != last_grant.
    - last_grant is updated on entry to BusyX; counter cleared to 0.
  - BusyX: s_rd_en, s_wr_en, s_byte_en, s_addr and s_wr_data driven combinationally from master X.
    - If mX_rd_en and mX_wr_en are both 1, s_wr_en is forced 0 and the read wins.
    - The other master's outputs stay 0.
- Arbitration latency: a request sampled in Idle reaches the slave 1 cycle later. Minimum transaction is 2 cycles (Idle, BusyX with s_ack).
- Completion: in BusyX with s_ack = 1, mX_ack = s_ack combinationally (same cycle) and next state is Idle. There is always one Idle turnaround cycle between grants, so a master dropping its enables on ack is never re-granted.
- Abort: in BusyX with reqX = 0 and s_ack = 0, next state is Idle and no ack is forwarded. s_* enables fall with the master's.
- Timeout (TIMEOUT != 0):
  - The counter increments each BusyX cycle with s_ack = 0.
  - In a BusyX cycle where counter == TIMEOUT and s_ack = 0:
    - mX_ack = 1 and mX_err = 1 for that cycle.
    - s_rd_en and s_wr_en are forced 0.
    - Next state is Idle.
  - s_ack in the same cycle as the timeout takes precedence: normal ack, no err.
  - The counter saturates; it never wraps.
- Read data: s_rd_data is routed to both m0_rd_data and m1_rd_data unconditionally. It is valid only with the matching mX_ack and err = 0.
- An s_ack arriving in Idle is ignored.

Test Plan:
- Single read, m0 only: m0_rd_en = 1, addr = 0x1000; slave acks 3 cycles after s_rd_en → s_rd_en rises 1 cycle after request, s_addr = 0x1000, m0_ack is a one-cycle pulse, m0_rd_data = slave value, m1_ack = 0.
- Simultaneous requests after reset: m0 read and m1 write (byte_en = 0x0F, data = 0xDEADBEEF) held together, slave acks immediately → m0 served first. After 1 Idle cycle m1 is served, s_wr_en = 1, s_byte_en = 0x0F. Repeating the pair yields order m0, m1, m0, m1.
- Timeout, TIMEOUT = 4: m1_wr_en held, slave never acks → m1_ack = 1 and m1_err = 1 on Busy cycle 5 (counter = 4). s_wr_en = 0 in that cycle. State returns to Idle.
- Ack at timeout boundary, TIMEOUT = 4: s_ack = 1 exactly when counter = 4 → m1_ack = 1, m1_err = 0.
- Abort and reset: m0 granted, m0_rd_en drops before ack → no m0_ack, Idle next cycle. Separately, reset_n pulled low mid-Busy → s_rd_en = 0 immediately; after release, m0 has priority again (last_grant = 1).
- Mixed rd+wr: m0_rd_en = 1 and m0_wr_en = 1 → s_rd_en = 1, s_wr_en = 0.
